// File: rtl/spi_reg_file_if.sv
// Byte-level link between the SPI shifter and the register-file decoder.
interface spi_reg_file_if;
  logic       frame_active;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] tx_data;

  modport master (
    output frame_active,
    output rx_valid,
    output rx_data,
    input  tx_data
  );

  modport slave (
    input  frame_active,
    input  rx_valid,
    input  rx_data,
    output tx_data
  );
endinterface

// File: rtl/spi_reg_file.sv
// SPI command decoder and register file: the first byte of a frame is a command
// (bit7 write, [6:0] start address); later bytes are data with auto-incrementing address.
module spi_reg_file #(
  parameter int unsigned NREGS  = 16,
  parameter logic [7:0]  DEV_ID = 8'h5A
) (
  input  logic               clk,
  input  logic               rst,
  spi_reg_file_if.slave      bus,
  output logic [NREGS*8-1:0] reg_q,
  output logic               wr_strobe,
  output logic [6:0]         wr_addr,
  output logic               addr_err
);

  localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [1:0] {StIdle, StCmd, StWr, StRd} state_e;

  state_e      state_q, state_d;
  logic [7:0]  tx_q, tx_d;
  logic [6:0]  addr_q, addr_d;
  logic [6:0]  addr_inc;
  logic        err_q, err_d;
  logic        fa_q;
  logic        wr_en;
  logic        wr_strobe_q;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  regs_q [NREGS];
  logic [7:0]  rd_cmd, rd_next;
  logic        cmd_in_range, cur_in_range, next_in_range;

  assign addr_inc      = addr_q + 7'd1;
  assign cmd_in_range  = 32'(bus.rx_data[6:0]) < NREGS;
  assign cur_in_range  = 32'(addr_q) < NREGS;
  assign next_in_range = 32'(addr_inc) < NREGS;
  assign rd_cmd        = cmd_in_range  ? regs_q[bus.rx_data[AW-1:0]] : 8'hFF;
  assign rd_next       = next_in_range ? regs_q[addr_inc[AW-1:0]]    : 8'hFF;

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    err_d     = err_q;
    wr_en     = 1'b0;
    wr_addr_d = wr_addr_q;
    // Frame end overrides everything, including an rx_valid on the same cycle.
    if (!bus.frame_active) begin
      state_d = StIdle;
      tx_d    = 8'h00;
    end else begin
      case (state_q)
        StIdle: begin
          if (!fa_q) begin
            state_d = StCmd;
            tx_d    = DEV_ID;
            err_d   = 1'b0;
          end
        end
        StCmd: begin
          if (bus.rx_valid) begin
            addr_d = bus.rx_data[6:0];
            if (bus.rx_data[7]) begin
              state_d = StWr;
              tx_d    = 8'h00;
            end else begin
              state_d = StRd;
              tx_d    = rd_cmd;
            end
          end
        end
        StWr: begin
          if (bus.rx_valid) begin
            if (cur_in_range) begin
              wr_en     = 1'b1;
              wr_addr_d = addr_q;
            end else begin
              err_d = 1'b1;
            end
            addr_d = addr_inc;
          end
        end
        StRd: begin
          if (bus.rx_valid) begin
            addr_d = addr_inc;
            tx_d   = rd_next;
            if (!cur_in_range) err_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // fa_q resets high so a frame already in progress at reset release is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      tx_q        <= 8'h00;
      addr_q      <= 7'd0;
      err_q       <= 1'b0;
      fa_q        <= 1'b1;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 7'd0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      fa_q        <= bus.frame_active;
      wr_strobe_q <= wr_en;
      wr_addr_q   <= wr_addr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= 8'h00;
    end else if (wr_en) begin
      regs_q[addr_q[AW-1:0]] <= bus.rx_data;
    end
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < int'(NREGS); i++) reg_q[8*i +: 8] = regs_q[i];
  end

  assign bus.tx_data = tx_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign addr_err    = err_q;

endmodule
